// File: rtl/pco_phase_detector_pkg.sv
// Shared PCO constants and FSM state encodings, used by the oscillator,
// this phase detector and the control neuron.
package pco_phase_detector_pkg;
    localparam int PCO_PHASE_W  = 4;
    localparam int PCO_PERIOD   = 2 ** PCO_PHASE_W;
    localparam int PCO_HIGH_LEN = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;
endpackage

// File: rtl/pco_phase_detector_edge_det.sv
// Registered previous-sample edge detector. prev resets to 1 so an input that
// is already high when reset releases does not look like a rising edge.
module pco_edge_det (
    input  logic clk,
    input  logic re_n,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic prev;

    always_ff @(posedge clk or negedge re_n) begin
        if (!re_n) prev <= 1'b1;
        else       prev <= d;
    end

    assign rise = d & ~prev;
    assign fall = ~d & prev;
endmodule

// File: rtl/pco_phase_detector.sv
// Recovers the phase of a PCO waveform by timing its rising edge against a
// local reference counter, checks the high/low shape and reports lock.
module pco_phase_detector
    import pco_phase_detector_pkg::*;
#(
    parameter int PHASE_W  = PCO_PHASE_W,
    parameter int HIGH_LEN = PCO_HIGH_LEN,
    parameter int LOCK_CNT = 3
) (
    input  logic               clk,
    input  logic               re_n,
    input  logic               align,
    input  logic               osc_in,
    output logic [PHASE_W-1:0] phase_out,
    output logic               phase_vld,
    output logic               lock,
    output logic               err
);
    localparam int CW = PHASE_W + 1;
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] HL = CW'(HIGH_LEN);
    localparam logic [CW-1:0] LL = CW'((2 ** PHASE_W) - HIGH_LEN);
    localparam logic [MW-1:0] LC = MW'(LOCK_CNT);

    logic [PHASE_W-1:0] cnt;
    logic [1:0]         state;
    logic [CW-1:0]      hcnt;
    logic [CW-1:0]      lcnt;
    logic [MW-1:0]      match;
    logic [MW-1:0]      match_nxt;
    logic               rise;
    logic               fall;

    pco_edge_det u_edge (
        .clk  (clk),
        .re_n (re_n),
        .d    (osc_in),
        .rise (rise),
        .fall (fall)
    );

    // A new measurement extends the run only if it repeats the held phase.
    always_comb begin
        match_nxt = MW'(1);
        if (cnt == phase_out)
            match_nxt = (match == LC) ? LC : match + MW'(1);
    end

    assign lock = (match == LC);

    always_ff @(posedge clk or negedge re_n) begin
        if (!re_n) begin
            cnt       <= '0;
            state     <= IDLE;
            hcnt      <= '0;
            lcnt      <= '0;
            phase_out <= '0;
            phase_vld <= 1'b0;
            err       <= 1'b0;
            match     <= '0;
        end else begin
            cnt       <= align ? '0 : cnt + 1'b1;
            phase_vld <= 1'b0;
            err       <= 1'b0;
            if (align) begin
                state <= IDLE;
                match <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= HIGH;
                            hcnt  <= CW'(1);
                        end
                    end
                    HIGH: begin
                        if (osc_in) begin
                            if (hcnt == HL) begin
                                err   <= 1'b1;
                                state <= IDLE;
                                match <= '0;
                            end else begin
                                hcnt <= hcnt + CW'(1);
                            end
                        end else if (fall) begin
                            if (hcnt == HL) begin
                                state <= LOW;
                                lcnt  <= CW'(1);
                            end else begin
                                err   <= 1'b1;
                                state <= IDLE;
                                match <= '0;
                            end
                        end
                    end
                    LOW: begin
                        if (!osc_in) begin
                            if (lcnt == LL) begin
                                err   <= 1'b1;
                                state <= IDLE;
                                match <= '0;
                            end else begin
                                lcnt <= lcnt + CW'(1);
                            end
                        end else if (rise) begin
                            // Every rise in LOW opens the next measurement, good or bad.
                            state <= HIGH;
                            hcnt  <= CW'(1);
                            if (lcnt == LL) begin
                                phase_vld <= 1'b1;
                                phase_out <= cnt;
                                match     <= match_nxt;
                            end else begin
                                err   <= 1'b1;
                                match <= '0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pco_phase_detector.sv
// Directed bench for pco_phase_detector: a timestamp-based reference model
// checked every cycle, plus hand-computed cycle/phase expectations.
module tb_pco_phase_detector;
    localparam int HL = 8;
    localparam int LL = 8;

    logic       clk = 1'b0;
    logic       re_n = 1'b0;
    logic       align = 1'b0;
    logic       osc_in = 1'b0;
    logic [3:0] phase_out;
    logic       phase_vld;
    logic       lock;
    logic       err;

    pco_phase_detector dut (
        .clk       (clk),
        .re_n      (re_n),
        .align     (align),
        .osc_in    (osc_in),
        .phase_out (phase_out),
        .phase_vld (phase_vld),
        .lock      (lock),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus state
    int t = 0;
    int ph = 0;
    int mode = 0;
    int align_at = -1;

    // per-cycle output log for literal checks
    logic       vld_log  [0:255];
    logic       lock_log [0:255];
    logic       err_log  [0:255];
    logic [3:0] ph_log   [0:255];

    // reference model: edge timestamps instead of counters
    int   mt = 0, cbase = 0, rise_t = 0, fall_t = 0;
    bit   armed = 0, fallen = 0, mprev = 1;
    bit   e_vld = 0, e_err = 0, e_lock = 0;
    logic [3:0] e_phase = 4'd0;
    int   hist[$];

    task automatic model_reset();
        mt = 0; cbase = 0; rise_t = 0; fall_t = 0;
        armed = 0; fallen = 0; mprev = 1;
        e_vld = 0; e_err = 0; e_lock = 0; e_phase = 4'd0;
        hist.delete();
    endtask

    task automatic model_step();
        bit r, f;
        int c;
        c = (mt - cbase) % 16;
        r = osc_in && !mprev;
        f = !osc_in && mprev;
        e_vld = 0;
        e_err = 0;
        if (align) begin
            armed = 0;
            hist.delete();
            cbase = mt + 1;
        end else if (!armed) begin
            if (r) begin armed = 1; fallen = 0; rise_t = mt; end
        end else if (!fallen) begin
            if (osc_in && (mt - rise_t) == HL) begin
                e_err = 1; armed = 0;
            end else if (f) begin
                if ((mt - rise_t) == HL) begin fallen = 1; fall_t = mt; end
                else begin e_err = 1; armed = 0; end
            end
        end else begin
            if (!osc_in && (mt - fall_t) == LL) begin
                e_err = 1; armed = 0;
            end else if (r) begin
                if ((mt - fall_t) == LL) begin
                    e_vld = 1;
                    e_phase = 4'(c);
                    hist.push_back(c);
                end else begin
                    e_err = 1;
                end
                rise_t = mt;
                fallen = 0;
            end
        end
        if (e_err) hist.delete();
        e_lock = 0;
        if (hist.size() >= 3)
            e_lock = (hist[$] == hist[$-1]) && (hist[$-1] == hist[$-2]);
        mprev = osc_in;
        mt++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_all();
        chk($sformatf("phase_vld@%0d", t), {31'd0, phase_vld}, int'(e_vld));
        chk($sformatf("err@%0d", t), {31'd0, err}, int'(e_err));
        chk($sformatf("lock@%0d", t), {31'd0, lock}, int'(e_lock));
        chk($sformatf("phase_out@%0d", t), {28'd0, phase_out}, int'(e_phase));
    endtask

    function automatic logic gen(input int k);
        if (mode == 1)
            // 3 low, 9 high, 7 low, 8 high, 7 low, 12 high, then low
            return (k >= 3 && k <= 11) || (k >= 19 && k <= 26) || (k >= 34 && k <= 45);
        return ((k - ph + 256) % 16) < 8;
    endfunction

    task automatic observe();
        if (t < 256) begin
            vld_log[t]  = phase_vld;
            lock_log[t] = lock;
            err_log[t]  = err;
            ph_log[t]   = phase_out;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (re_n) model_step();
        else      model_reset();
        @(negedge clk);
        check_all();
        observe();
        osc_in = gen(t);
        align  = (t == align_at);
        t++;
    endtask

    task automatic run_to(input int tend);
        while (t < tend) cycle();
    endtask

    task automatic do_reset();
        re_n = 1'b0;
        align = 1'b0;
        osc_in = 1'b0;
        align_at = -1;
        model_reset();
        for (int i = 0; i < 256; i++) begin
            vld_log[i] = 0; lock_log[i] = 0; err_log[i] = 0; ph_log[i] = 0;
        end
        repeat (2) @(negedge clk);
        re_n = 1'b1;
        t = 0;
        check_all();
        observe();
        osc_in = gen(0);
        t = 1;
    endtask

    function automatic int count_vld(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += int'(vld_log[i]);
        return n;
    endfunction

    function automatic int count_err(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += int'(err_log[i]);
        return n;
    endfunction

    initial begin
        // 1: phase 5, lock after three equal measurements
        mode = 0; ph = 5;
        do_reset();
        run_to(60);
        chk("t1_vld22", {31'd0, vld_log[22]}, 1);
        chk("t1_ph22", {28'd0, ph_log[22]}, 5);
        chk("t1_vld38", {31'd0, vld_log[38]}, 1);
        chk("t1_vld54", {31'd0, vld_log[54]}, 1);
        chk("t1_nvld", count_vld(0, 59), 3);
        chk("t1_lock53", {31'd0, lock_log[53]}, 0);
        chk("t1_lock54", {31'd0, lock_log[54]}, 1);

        // 2: phase 0, the rise at release is not an edge
        ph = 0;
        do_reset();
        run_to(40);
        chk("t2_novld", count_vld(0, 32), 0);
        chk("t2_vld33", {31'd0, vld_log[33]}, 1);
        chk("t2_ph33", {28'd0, ph_log[33]}, 0);
        chk("t2_noerr", count_err(0, 39), 0);

        // 3: full sweep including counter wrap
        for (int p = 0; p < 16; p++) begin
            int ev;
            ph = p;
            ev = (p == 0) ? 33 : p + 17;
            do_reset();
            run_to(40);
            chk($sformatf("t3_vld_p%0d", p), {31'd0, vld_log[ev]}, 1);
            chk($sformatf("t3_ph_p%0d", p), {28'd0, ph_log[ev]}, p);
            chk($sformatf("t3_early_p%0d", p), count_vld(0, ev - 1), 0);
        end

        // 4: locked at 5, jump to 9 mid-high
        ph = 5;
        do_reset();
        run_to(56);
        ph = 9;
        run_to(115);
        chk("t4_lock56", {31'd0, lock_log[56]}, 1);
        chk("t4_err57", {31'd0, err_log[57]}, 1);
        chk("t4_lock57", {31'd0, lock_log[57]}, 0);
        chk("t4_vld74", {31'd0, vld_log[74]}, 1);
        chk("t4_ph74", {28'd0, ph_log[74]}, 9);
        chk("t4_lock105", {31'd0, lock_log[105]}, 0);
        chk("t4_lock106", {31'd0, lock_log[106]}, 1);

        // 5: malformed waveform, long high then short low
        mode = 1;
        do_reset();
        run_to(70);
        chk("t5_err12", {31'd0, err_log[12]}, 1);
        chk("t5_err35", {31'd0, err_log[35]}, 1);
        chk("t5_err43", {31'd0, err_log[43]}, 1);
        chk("t5_nerr", count_err(0, 69), 3);
        chk("t5_novld", count_vld(0, 69), 0);

        // 6: align while locked, then reset mid-HIGH
        mode = 0; ph = 5;
        do_reset();
        align_at = 60;
        run_to(103);
        chk("t6_lock60", {31'd0, lock_log[60]}, 1);
        chk("t6_lock61", {31'd0, lock_log[61]}, 0);
        chk("t6_hold61", {28'd0, ph_log[61]}, 5);
        chk("t6_noerr", count_err(61, 102), 0);
        chk("t6_vld86", {31'd0, vld_log[86]}, 1);
        chk("t6_ph86", {28'd0, ph_log[86]}, 8);
        chk("t6_ph102", {28'd0, ph_log[102]}, 8);
        #2 re_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_ph", {28'd0, phase_out}, 0);
        chk("t6_rst_vld", {31'd0, phase_vld}, 0);
        chk("t6_rst_lock", {31'd0, lock}, 0);
        chk("t6_rst_err", {31'd0, err}, 0);
        ph = 3;
        do_reset();
        run_to(30);
        chk("t6_vld20", {31'd0, vld_log[20]}, 1);
        chk("t6_ph20", {28'd0, ph_log[20]}, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
